// File: rtl/ex_mem_ccr_stage_if.sv
// EX->MEM boundary bundle: pipeline control, EX-side operands and the registered MEM-side view.
// The master drives EX and pipeline control; the slave is the stage register itself.
interface ex_mem_ccr_stage_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CCR_W   = 3,
  parameter int unsigned RADDR_W = 3
);
  logic               stall;
  logic               flush;
  logic               ex_valid;
  logic [DATA_W-1:0]  alu_out;
  logic [CCR_W-1:0]   alu_ccr;
  logic               ccr_we;
  logic               setc;
  logic               clrc;
  logic               ccr_save;
  logic               ccr_restore;
  logic [DATA_W-1:0]  ex_store_data;
  logic [RADDR_W-1:0] ex_rd_addr;
  logic               ex_mem_read;
  logic               ex_mem_write;
  logic               ex_reg_write;

  logic               mem_valid;
  logic [DATA_W-1:0]  mem_alu_out;
  logic [DATA_W-1:0]  mem_store_data;
  logic [RADDR_W-1:0] mem_rd_addr;
  logic               mem_mem_read;
  logic               mem_mem_write;
  logic               mem_reg_write;
  logic [CCR_W-1:0]   ccr;
  logic [CCR_W-1:0]   ccr_shadow;

  modport master (
    output stall, flush, ex_valid, alu_out, alu_ccr, ccr_we, setc, clrc,
           ccr_save, ccr_restore, ex_store_data, ex_rd_addr,
           ex_mem_read, ex_mem_write, ex_reg_write,
    input  mem_valid, mem_alu_out, mem_store_data, mem_rd_addr,
           mem_mem_read, mem_mem_write, mem_reg_write, ccr, ccr_shadow
  );

  modport slave (
    input  stall, flush, ex_valid, alu_out, alu_ccr, ccr_we, setc, clrc,
           ccr_save, ccr_restore, ex_store_data, ex_rd_addr,
           ex_mem_read, ex_mem_write, ex_reg_write,
    output mem_valid, mem_alu_out, mem_store_data, mem_rd_addr,
           mem_mem_read, mem_mem_write, mem_reg_write, ccr, ccr_shadow
  );
endinterface

// File: rtl/ex_mem_ccr_stage.sv
// EX/MEM pipeline register with the architectural condition-code register and its
// interrupt shadow copy. Priority per edge: rst > stall > flush > normal.
module ex_mem_ccr_stage #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CCR_W   = 3,
  parameter int unsigned RADDR_W = 3
) (
  input logic                clk,
  input logic                rst,
  ex_mem_ccr_stage_if.slave  bus
);
  localparam int unsigned C_BIT = 2;

  logic               valid_q;
  logic [DATA_W-1:0]  alu_q;
  logic [DATA_W-1:0]  store_q;
  logic [RADDR_W-1:0] rd_q;
  logic               mrd_q;
  logic               mwr_q;
  logic               rwr_q;
  logic [CCR_W-1:0]   ccr_q;
  logic [CCR_W-1:0]   shadow_q;

  logic               commit;
  logic [CCR_W-1:0]   ccr_next;
  logic [CCR_W-1:0]   shadow_next;

  assign commit = bus.ex_valid & ~bus.stall & ~bus.flush;

  // Restore overrides everything; otherwise ccr_we loads all flags and setc/clrc then
  // override only C, which yields Z,N from the ALU with C forced when both are present.
  always_comb begin
    ccr_next    = ccr_q;
    shadow_next = shadow_q;
    if (commit) begin
      if (bus.ccr_restore) begin
        ccr_next = shadow_q;
      end else begin
        if (bus.ccr_we)
          ccr_next = bus.alu_ccr;
        if (bus.setc | bus.clrc)
          ccr_next[C_BIT] = ~bus.clrc;
      end
      if (bus.ccr_save)
        shadow_next = ccr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      alu_q    <= '0;
      store_q  <= '0;
      rd_q     <= '0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      rwr_q    <= 1'b0;
      ccr_q    <= '0;
      shadow_q <= '0;
    end else if (!bus.stall) begin
      if (bus.flush) begin
        valid_q <= 1'b0;
        alu_q   <= '0;
        store_q <= '0;
        rd_q    <= '0;
        mrd_q   <= 1'b0;
        mwr_q   <= 1'b0;
        rwr_q   <= 1'b0;
      end else begin
        valid_q <= bus.ex_valid;
        alu_q   <= bus.alu_out;
        store_q <= bus.ex_store_data;
        rd_q    <= bus.ex_rd_addr;
        mrd_q   <= bus.ex_mem_read  & bus.ex_valid;
        mwr_q   <= bus.ex_mem_write & bus.ex_valid;
        rwr_q   <= bus.ex_reg_write & bus.ex_valid;
      end
      ccr_q    <= ccr_next;
      shadow_q <= shadow_next;
    end
  end

  assign bus.mem_valid      = valid_q;
  assign bus.mem_alu_out    = alu_q;
  assign bus.mem_store_data = store_q;
  assign bus.mem_rd_addr    = rd_q;
  assign bus.mem_mem_read   = mrd_q;
  assign bus.mem_mem_write  = mwr_q;
  assign bus.mem_reg_write  = rwr_q;
  assign bus.ccr            = ccr_q;
  assign bus.ccr_shadow     = shadow_q;
endmodule

// File: tb/tb_ex_mem_ccr_stage.sv
// Bench for ex_mem_ccr_stage: directed vector table, hand-written stall/flush sequence,
// then randomized traffic against a behavioural model.
module tb_ex_mem_ccr_stage;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [15:0] alu_out;
    logic [2:0]  alu_ccr;
    logic        ccr_we;
    logic        setc;
    logic        clrc;
    logic        save;
    logic        restore;
    logic [15:0] sd;
    logic [2:0]  rd;
    logic        mr;
    logic        mw;
    logic        rw;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] alu;
    logic [15:0] sd;
    logic [2:0]  rd;
    logic        mr;
    logic        mw;
    logic        rw;
    logic [2:0]  ccr;
    logic [2:0]  sh;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_mem_ccr_stage_if #(.DATA_W(16), .CCR_W(3), .RADDR_W(3)) bus ();

  ex_mem_ccr_stage #(.DATA_W(16), .CCR_W(3), .RADDR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  vec_t tbl [20];

  task automatic drive(input in_t v);
    rst               = v.rst;
    bus.stall         = v.stall;
    bus.flush         = v.flush;
    bus.ex_valid      = v.ex_valid;
    bus.alu_out       = v.alu_out;
    bus.alu_ccr       = v.alu_ccr;
    bus.ccr_we        = v.ccr_we;
    bus.setc          = v.setc;
    bus.clrc          = v.clrc;
    bus.ccr_save      = v.save;
    bus.ccr_restore   = v.restore;
    bus.ex_store_data = v.sd;
    bus.ex_rd_addr    = v.rd;
    bus.ex_mem_read   = v.mr;
    bus.ex_mem_write  = v.mw;
    bus.ex_reg_write  = v.rw;
  endtask

  function automatic out_t sample();
    return '{bus.mem_valid, bus.mem_alu_out, bus.mem_store_data, bus.mem_rd_addr,
             bus.mem_mem_read, bus.mem_mem_write, bus.mem_reg_write, bus.ccr, bus.ccr_shadow};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input out_t act, input out_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got valid=%0b alu=%h sd=%h rd=%0d mr/mw/rw=%0b%0b%0b ccr=%b sh=%b, expected valid=%0b alu=%h sd=%h rd=%0d mr/mw/rw=%0b%0b%0b ccr=%b sh=%b",
               name, act.valid, act.alu, act.sd, act.rd, act.mr, act.mw, act.rw, act.ccr, act.sh,
               exp.valid, exp.alu, exp.sd, exp.rd, exp.mr, exp.mw, exp.rw, exp.ccr, exp.sh);
    end
  endtask

  // Flags kept as separate Z/N/C booleans; C is resolved after the bulk flag update.
  function automatic out_t model(input out_t s, input in_t v);
    out_t n;
    logic z, nf, c;
    n = s;
    if (v.rst) return '0;
    if (v.stall) return s;
    if (v.flush) begin
      n.valid = 0; n.alu = 0; n.sd = 0; n.rd = 0; n.mr = 0; n.mw = 0; n.rw = 0;
      return n;
    end
    n.valid = v.ex_valid;
    n.alu   = v.alu_out;
    n.sd    = v.sd;
    n.rd    = v.rd;
    n.mr    = v.mr && v.ex_valid;
    n.mw    = v.mw && v.ex_valid;
    n.rw    = v.rw && v.ex_valid;
    if (v.ex_valid) begin
      z = s.ccr[0]; nf = s.ccr[1]; c = s.ccr[2];
      if (v.restore) begin
        z = s.sh[0]; nf = s.sh[1]; c = s.sh[2];
      end else begin
        if (v.ccr_we) begin
          z = v.alu_ccr[0]; nf = v.alu_ccr[1]; c = v.alu_ccr[2];
        end
        if (v.clrc) c = 0;
        else if (v.setc) c = 1;
      end
      if (v.save) n.sh = s.ccr;
      n.ccr = {c, nf, z};
    end
    return n;
  endfunction

  initial begin
    in_t  vi;
    out_t st;
    out_t e;

    //          rst stall flush v  alu        accr  we setc clrc sv rs  sd         rd    mr mw rw      valid alu       sd        rd    mr mw rw ccr   sh
    tbl[0]  = '{'{H,H,H,H,16'hFFFF,3'd7,H,H,H,H,H,16'hFFFF,3'd7,H,H,H}, '{L,16'h0000,16'h0000,3'd0,L,L,L,3'b000,3'b000}};
    tbl[1]  = '{'{L,L,L,H,16'h1234,3'd0,L,L,L,L,L,16'h0000,3'd3,L,L,H}, '{H,16'h1234,16'h0000,3'd3,L,L,H,3'b000,3'b000}};
    tbl[2]  = '{'{L,L,L,H,16'h0011,3'd1,H,L,L,L,L,16'h0000,3'd0,L,L,L}, '{H,16'h0011,16'h0000,3'd0,L,L,L,3'b001,3'b000}};
    tbl[3]  = '{'{L,L,L,H,16'h0022,3'd0,L,H,L,L,L,16'h0000,3'd2,H,L,H}, '{H,16'h0022,16'h0000,3'd2,H,L,H,3'b101,3'b000}};
    tbl[4]  = '{'{L,L,L,H,16'h0044,3'd0,L,H,H,L,L,16'hABCD,3'd4,L,H,L}, '{H,16'h0044,16'hABCD,3'd4,L,H,L,3'b001,3'b000}};
    tbl[5]  = '{'{L,H,L,H,16'hFFFF,3'd6,H,L,L,H,L,16'h1111,3'd7,H,H,H}, '{H,16'h0044,16'hABCD,3'd4,L,H,L,3'b001,3'b000}};
    tbl[6]  = tbl[5];
    tbl[7]  = tbl[5];
    tbl[8]  = '{'{L,L,L,H,16'hFFFF,3'd6,H,L,L,L,L,16'h0000,3'd1,L,L,H}, '{H,16'hFFFF,16'h0000,3'd1,L,L,H,3'b110,3'b000}};
    tbl[9]  = '{'{L,L,H,H,16'h0055,3'd3,H,L,L,L,L,16'h2222,3'd2,L,H,H}, '{L,16'h0000,16'h0000,3'd0,L,L,L,3'b110,3'b000}};
    tbl[10] = '{'{L,L,L,H,16'h0066,3'd0,L,L,L,H,L,16'h0000,3'd0,L,L,L}, '{H,16'h0066,16'h0000,3'd0,L,L,L,3'b110,3'b110}};
    tbl[11] = '{'{L,L,L,H,16'h0077,3'd1,H,L,L,L,L,16'h0000,3'd0,L,L,L}, '{H,16'h0077,16'h0000,3'd0,L,L,L,3'b001,3'b110}};
    tbl[12] = '{'{L,L,L,H,16'h0088,3'd0,L,L,L,L,H,16'h0000,3'd0,L,L,L}, '{H,16'h0088,16'h0000,3'd0,L,L,L,3'b110,3'b110}};
    tbl[13] = '{'{L,L,L,H,16'h0099,3'd1,H,L,L,L,L,16'h0000,3'd0,L,L,L}, '{H,16'h0099,16'h0000,3'd0,L,L,L,3'b001,3'b110}};
    tbl[14] = '{'{L,L,L,H,16'h00AA,3'd0,L,L,L,H,H,16'h0000,3'd0,L,L,L}, '{H,16'h00AA,16'h0000,3'd0,L,L,L,3'b110,3'b001}};
    tbl[15] = '{'{L,L,L,L,16'h5555,3'd7,H,L,L,L,L,16'h0000,3'd5,L,L,H}, '{L,16'h5555,16'h0000,3'd5,L,L,L,3'b110,3'b001}};
    tbl[16] = '{'{L,L,L,H,16'h00BB,3'd1,H,L,H,L,L,16'h0000,3'd0,L,L,L}, '{H,16'h00BB,16'h0000,3'd0,L,L,L,3'b001,3'b001}};
    tbl[17] = '{'{L,L,L,H,16'h00CC,3'd3,H,H,L,L,L,16'h0000,3'd0,L,L,L}, '{H,16'h00CC,16'h0000,3'd0,L,L,L,3'b111,3'b001}};
    tbl[18] = '{'{L,L,L,H,16'h00DD,3'd0,H,L,H,L,H,16'h0000,3'd0,L,L,L}, '{H,16'h00DD,16'h0000,3'd0,L,L,L,3'b001,3'b001}};
    tbl[19] = '{'{H,H,L,H,16'h7777,3'd7,H,H,L,H,H,16'h7777,3'd7,H,H,H}, '{L,16'h0000,16'h0000,3'd0,L,L,L,3'b000,3'b000}};

    drive(tbl[0].i);
    step();
    for (int k = 0; k < 20; k++) begin
      drive(tbl[k].i);
      step();
      check($sformatf("table[%0d]", k), sample(), tbl[k].o);
    end

    // Stall dominates a simultaneous flush; a later flush alone inserts the bubble.
    vi = '0; vi.ex_valid = 1; vi.alu_out = 16'h0F0F; vi.rd = 3'd6; vi.rw = 1; vi.ccr_we = 1; vi.alu_ccr = 3'b010;
    drive(vi); step();
    e = '{H,16'h0F0F,16'h0000,3'd6,L,L,H,3'b010,3'b000};
    check("seq_load", sample(), e);
    vi.stall = 1; vi.flush = 1; vi.alu_ccr = 3'b101;
    drive(vi); step();
    check("seq_stall_flush", sample(), e);
    vi.stall = 0;
    drive(vi); step();
    e = '{L,16'h0000,16'h0000,3'd0,L,L,L,3'b010,3'b000};
    check("seq_flush", sample(), e);
    vi = '0; vi.stall = 1; vi.rst = 1; vi.ex_valid = 1; vi.alu_out = 16'h1;
    drive(vi); step();
    check("seq_rst_clear", sample(), '0);

    st = '0;
    for (int n = 0; n < 400; n++) begin
      vi.rst      = ($urandom_range(39) == 0);
      vi.stall    = ($urandom_range(5) == 0);
      vi.flush    = ($urandom_range(7) == 0);
      vi.ex_valid = ($urandom_range(3) != 0);
      vi.alu_out  = 16'($urandom);
      vi.alu_ccr  = 3'($urandom);
      vi.ccr_we   = ($urandom_range(1) == 0);
      vi.setc     = ($urandom_range(3) == 0);
      vi.clrc     = ($urandom_range(3) == 0);
      vi.save     = ($urandom_range(3) == 0);
      vi.restore  = ($urandom_range(3) == 0);
      vi.sd       = 16'($urandom);
      vi.rd       = 3'($urandom);
      vi.mr       = 1'($urandom);
      vi.mw       = 1'($urandom);
      vi.rw       = 1'($urandom);
      drive(vi);
      step();
      st = model(st, vi);
      check($sformatf("rand[%0d]", n), sample(), st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
